score_conv_scheduler: RTL and testbench
=======================================

SCORE_CONV_SCHEDULER -- requirements
Module: score_conv_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 32, the number of WAIT cycles without conv_done_i before the conversion is aborted (range 2..255).
REQ-002 Parameter CLAMP, default 1, enables saturation of inputs above 99 to 99 when set to 1.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  2  per-channel conversion request (bit0 = channel 0, bit1 = channel 1), sampled every edge.
REQ-006 bin0_i / bin1_i  input  7 each  binary score of channel 0 / channel 1.
REQ-007 conv_start_o  output  1  one-cycle start strobe to the shared serial binary-to-BCD converter.
REQ-008 conv_bin_o  output  7  operand to the converter, registered, held constant from ISSUE through the end of WAIT.
REQ-009 conv_done_i  input  1  converter completion strobe; conv_tens_i/conv_ones_i (4 bits each) valid when it is high.
REQ-010 tens0_o, ones0_o, tens1_o, ones1_o  output  4 each  registered BCD result per channel.
REQ-011 valid_o  output  2  one-cycle pulse per channel when that channel's result registers update.
REQ-012 ovf_o  output  2  per channel, set when the last issued operand for that channel was clamped.
REQ-013 busy_o  output  1  high whenever the state is not IDLE.
REQ-014 err_o  output  1  sticky timeout flag.

Function
REQ-015 Pending: pend[c] shall set on any edge where req_i[c]=1, and clear only when channel c is granted. Set wins over clear on the same edge.
REQ-016 FSM states shall be IDLE, ISSUE and WAIT.
REQ-017 IDLE transition: if any pend bit is set at an edge, the FSM shall grant one channel, latch its operand into conv_bin_o, and go to ISSUE. Otherwise it shall stay in IDLE.
REQ-018 Arbitration shall be round-robin: if both pend bits are set, grant the channel not granted last. The last-grant pointer resets to 1, so channel 0 wins the first tie.
REQ-019 Operand: if CLAMP=1 and bin>99, conv_bin_o=99 and ovf_o[c] is set; otherwise conv_bin_o=bin and ovf_o[c] is cleared. The operand is sampled at grant; later input changes do not affect the conversion in flight.
REQ-020 ISSUE: conv_start_o shall be high for exactly this one cycle, and the FSM shall go to WAIT on the next edge.
REQ-021 WAIT: on an edge with conv_done_i=1, the FSM shall write conv_tens_i/conv_ones_i into the granted channel's registers, pulse valid_o[c] in the following cycle, clear the timeout counter, and return to IDLE.
REQ-022 WAIT timeout: after TIMEOUT consecutive WAIT edges without done, the FSM shall set err_o, leave the result registers unchanged, emit no valid pulse, and return to IDLE. pend is not re-set; the channel must re-request.
REQ-023 conv_done_i outside WAIT shall be ignored.
REQ-024 A request for the channel currently in ISSUE/WAIT shall set pend again and cause a fresh conversion after the current one finishes.
REQ-025 Minimum latency: req_i at edge k → pend at k → ISSUE at k+1 → WAIT at k+2 → valid_o one cycle after the done edge.
REQ-026 conv_start_o shall never be asserted while busy with a prior conversion; at most one conversion is in flight.

Reset
REQ-027 While rst_i=1 at an edge, the block shall enter IDLE and clear pend, the timeout counter and err_o. The last-grant pointer goes to 1.
REQ-028 While rst_i=1 at an edge, all outputs shall be cleared: tens*/ones* 0, valid_o 0, ovf_o 0, conv_start_o 0, conv_bin_o 0, busy_o 0.
REQ-029 Reset asserted mid-conversion shall abandon it, and a later conv_done_i shall be ignored.

Verification
REQ-030 Single request: req_i=01 with bin0_i=42, model converter done 8 cycles after start returning 4/2 -> conv_bin_o=42, exactly one start pulse, tens0=4, ones0=2, valid_o=01 for one cycle, channel 1 registers unchanged.
REQ-031 Simultaneous requests: req_i=11 pulse with bin0=7 and bin1=93 -> channel 0 served first, then channel 1; results 0/7 and 9/3; two valid pulses in order 01 then 10.
REQ-032 Clamp: bin1_i=120 requested -> conv_bin_o=99, ovf_o[1]=1, tens1=9, ones1=9. A following request with bin1_i=15 -> ovf_o[1]=0.
REQ-033 Timeout: converter never returns done -> busy_o falls after TIMEOUT WAIT cycles, err_o=1 and stays 1, no valid pulse, result registers hold their old value.
REQ-034 Re-request in flight: req_i[0] pulses during WAIT for channel 0 -> a second start follows the first completion, and bin0_i is re-sampled at the second grant.
REQ-035 Mid-operation reset: rst_i high for 1 cycle during WAIT -> all outputs 0, state IDLE, and a late conv_done_i produces no valid pulse.

Source files
------------

// File: rtl/score_conv_scheduler_if.sv
// Handshake between the score scheduler and the shared serial binary-to-BCD converter.
interface score_conv_scheduler_if;
    localparam int unsigned BIN_W = 7;
    localparam int unsigned BCD_W = 4;

    logic             conv_start_o;
    logic [BIN_W-1:0] conv_bin_o;
    logic             conv_done_i;
    logic [BCD_W-1:0] conv_tens_i;
    logic [BCD_W-1:0] conv_ones_i;

    // Scheduler side: issues operands, consumes BCD results.
    modport master (
        output conv_start_o,
        output conv_bin_o,
        input  conv_done_i,
        input  conv_tens_i,
        input  conv_ones_i
    );

    // Converter side.
    modport slave (
        input  conv_start_o,
        input  conv_bin_o,
        output conv_done_i,
        output conv_tens_i,
        output conv_ones_i
    );
endinterface

// File: rtl/score_conv_scheduler.sv
// Round-robin scheduler sharing one serial binary-to-BCD converter between two
// score channels, with operand clamping, per-channel result registers and a
// sticky timeout error.
module score_conv_scheduler #(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CLAMP   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_i,
    input  logic [6:0]              bin0_i,
    input  logic [6:0]              bin1_i,
    score_conv_scheduler_if.master  conv,
    output logic [3:0]              tens0_o,
    output logic [3:0]              ones0_o,
    output logic [3:0]              tens1_o,
    output logic [3:0]              ones1_o,
    output logic [1:0]              valid_o,
    output logic [1:0]              ovf_o,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int unsigned BIN_W = 7;
    localparam int unsigned BCD_W = 4;
    localparam int unsigned TMR_W = 8;
    localparam logic [BIN_W-1:0] SCORE_MAX = BIN_W'(99);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         pend_q, pend_d;
    logic               last_q, last_d;
    logic               cur_q, cur_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   tens0_q, tens0_d, ones0_q, ones0_d;
    logic [BCD_W-1:0]   tens1_q, tens1_d, ones1_q, ones1_d;
    logic [1:0]         valid_q, valid_d;
    logic [1:0]         ovf_q, ovf_d;
    logic               busy_q, busy_d;

    logic               gnt;
    logic [1:0]         gnt_oh;
    logic               clamp0, clamp1;
    logic [BIN_W-1:0]   op0, op1;

    // Operand saturation, evaluated continuously and captured only at grant.
    always_comb begin
        clamp0 = (CLAMP == 1) && (bin0_i > SCORE_MAX);
        clamp1 = (CLAMP == 1) && (bin1_i > SCORE_MAX);
        op0    = clamp0 ? SCORE_MAX : bin0_i;
        op1    = clamp1 ? SCORE_MAX : bin1_i;
    end

    // Next-state and next-output logic for the IDLE/ISSUE/WAIT sequencer.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | req_i;
        last_d  = last_q;
        cur_d   = cur_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        start_d = 1'b0;
        bin_d   = bin_q;
        tens0_d = tens0_q;
        ones0_d = ones0_q;
        tens1_d = tens1_q;
        ones1_d = ones1_q;
        valid_d = 2'b00;
        ovf_d   = ovf_q;
        gnt     = (pend_q == 2'b11) ? ~last_q : pend_q[1];
        gnt_oh  = gnt ? 2'b10 : 2'b01;

        case (state_q)
            S_IDLE: begin
                if (pend_q != 2'b00) begin
                    // A new request on the same edge re-arms the granted channel.
                    pend_d     = (pend_q & ~gnt_oh) | req_i;
                    bin_d      = gnt ? op1 : op0;
                    ovf_d[gnt] = gnt ? clamp1 : clamp0;
                    cur_d      = gnt;
                    last_d     = gnt;
                    tmr_d      = '0;
                    start_d    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (conv.conv_done_i) begin
                    if (cur_q) begin
                        tens1_d = conv.conv_tens_i;
                        ones1_d = conv.conv_ones_i;
                    end else begin
                        tens0_d = conv.conv_tens_i;
                        ones0_d = conv.conv_ones_i;
                    end
                    valid_d = cur_q ? 2'b10 : 2'b01;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    // Converter never answered: abandon without touching results.
                    err_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = TMR_W'(tmr_q + 1'b1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any conversion in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pend_q  <= 2'b00;
            last_q  <= 1'b1;
            cur_q   <= 1'b0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            bin_q   <= '0;
            tens0_q <= '0;
            ones0_q <= '0;
            tens1_q <= '0;
            ones1_q <= '0;
            valid_q <= 2'b00;
            ovf_q   <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            start_q <= start_d;
            bin_q   <= bin_d;
            tens0_q <= tens0_d;
            ones0_q <= ones0_d;
            tens1_q <= tens1_d;
            ones1_q <= ones1_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

    assign conv.conv_start_o = start_q;
    assign conv.conv_bin_o   = bin_q;
    assign tens0_o           = tens0_q;
    assign ones0_o           = ones0_q;
    assign tens1_o           = tens1_q;
    assign ones1_o           = ones1_q;
    assign valid_o           = valid_q;
    assign ovf_o             = ovf_q;
    assign busy_o            = busy_q;
    assign err_o             = err_q;
endmodule

// File: tb/tb_score_conv_scheduler.sv
// Randomized self-checking bench for score_conv_scheduler with a behavioural
// converter and a transaction-level expectation model.
module tb_score_conv_scheduler;
    localparam int unsigned TIMEOUT = 32;

    logic       clk_i  = 1'b0;
    logic       rst_i  = 1'b1;
    logic [1:0] req_i  = 2'b00;
    logic [6:0] bin0_i = 7'd0;
    logic [6:0] bin1_i = 7'd0;
    logic [3:0] tens0_o, ones0_o, tens1_o, ones1_o;
    logic [1:0] valid_o, ovf_o;
    logic       busy_o, err_o;

    score_conv_scheduler_if cif ();

    score_conv_scheduler #(.TIMEOUT(TIMEOUT), .CLAMP(1)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .bin0_i  (bin0_i),
        .bin1_i  (bin1_i),
        .conv    (cif.master),
        .tens0_o (tens0_o),
        .ones0_o (ones0_o),
        .tens1_o (tens1_o),
        .ones1_o (ones1_o),
        .valid_o (valid_o),
        .ovf_o   (ovf_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural converter and bus monitor state.
    int         conv_delay  = 4;
    bit         conv_mute   = 1'b0;
    bit         armed       = 1'b0;
    int         cnt         = 0;
    logic [6:0] op          = 7'd0;
    int         start_count = 0;
    int         viol        = 0;
    bit         prev_busy   = 1'b0;

    typedef struct {
        int         ch;
        logic [3:0] t;
        logic [3:0] o;
    } ev_t;
    ev_t vq[$];

    // Expected architectural state.
    logic [3:0] m_tens[2];
    logic [3:0] m_ones[2];
    logic [1:0] m_ovf;
    logic       m_err;
    int         m_last;

    function automatic logic [6:0] clamp_op(input logic [6:0] b);
        return (b > 7'd99) ? 7'd99 : b;
    endfunction

    function automatic logic ovf_of(input logic [6:0] b);
        return b > 7'd99;
    endfunction

    // Converter answers D cycles after seeing start; monitors start/hold/valid.
    always @(negedge clk_i) begin
        ev_t e;
        cif.conv_done_i = 1'b0;
        cif.conv_tens_i = 4'($urandom);
        cif.conv_ones_i = 4'($urandom);
        if (armed) begin
            cnt--;
            if (cnt == 0) begin
                cif.conv_done_i = 1'b1;
                cif.conv_tens_i = 4'(op / 7'd10);
                cif.conv_ones_i = 4'(op % 7'd10);
                armed = 1'b0;
            end
        end
        if (busy_o === 1'b1 && cif.conv_start_o !== 1'b1 && cif.conv_bin_o !== op) viol++;
        if (cif.conv_start_o === 1'b1) begin
            if (prev_busy) viol++;
            start_count++;
            op    = cif.conv_bin_o;
            cnt   = conv_delay;
            armed = !conv_mute;
        end
        prev_busy = (busy_o === 1'b1);
        if (valid_o !== 2'b00) begin
            e.ch = (valid_o === 2'b01) ? 0 : (valid_o === 2'b10) ? 1 : 3;
            e.t  = (e.ch == 1) ? tens1_o : tens0_o;
            e.o  = (e.ch == 1) ? ones1_o : ones0_o;
            vq.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_clear();
        m_tens[0] = 4'd0; m_tens[1] = 4'd0;
        m_ones[0] = 4'd0; m_ones[1] = 4'd0;
        m_ovf  = 2'b00;
        m_err  = 1'b0;
        m_last = 1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = 2'b00;
        tick();
        tick();
        rst_i = 1'b0;
        model_clear();
        vq.delete();
    endtask

    task automatic wait_events(input int n, input int max);
        for (int i = 0; i < max; i++) begin
            if (vq.size() >= n) return;
            tick();
        end
        vectors++; miscompares++;
        $display("FAIL wait_valid: got %0d valid pulses, required %0d", vq.size(), n);
    endtask

    task automatic settle(input int max);
        int idle = 0;
        for (int i = 0; i < max; i++) begin
            if (busy_o === 1'b0) idle++; else idle = 0;
            if (idle >= 3) return;
            tick();
        end
        vectors++; miscompares++;
        $display("FAIL settle: busy_o=%b after %0d cycles, required 0", busy_o, max);
    endtask

    // One request on channel c with operand b; converter answers after d cycles.
    task automatic single_xfer(input int c, input logic [6:0] b, input int d);
        logic [6:0] eop = clamp_op(b);
        int         s0  = start_count;
        vq.delete();
        conv_delay = d;
        if (c == 0) bin0_i = b; else bin1_i = b;
        req_i = 2'(1 << c);
        tick();
        req_i = 2'b00;
        vectors++;
        if (cif.conv_start_o !== 1'b0) begin
            miscompares++; $display("FAIL start_early: got %b, required 0", cif.conv_start_o);
        end
        tick();
        vectors++;
        if ({cif.conv_start_o, busy_o} !== 2'b11) begin
            miscompares++; $display("FAIL issue_latency: start/busy got %b%b, required 11", cif.conv_start_o, busy_o);
        end
        vectors++;
        if (cif.conv_bin_o !== eop) begin
            miscompares++; $display("FAIL operand: got %0d, required %0d", cif.conv_bin_o, eop);
        end
        vectors++;
        if (ovf_o[c] !== ovf_of(b)) begin
            miscompares++; $display("FAIL ovf_at_grant: ch%0d got %b, required %b", c, ovf_o[c], ovf_of(b));
        end
        if (c == 0) bin0_i = 7'($urandom); else bin1_i = 7'($urandom);
        wait_events(1, 60);
        settle(20);
        m_tens[c] = 4'(eop / 7'd10);
        m_ones[c] = 4'(eop % 7'd10);
        m_ovf[c]  = ovf_of(b);
        m_last    = c;
        vectors++;
        if (vq.size() != 1) begin
            miscompares++; $display("FAIL valid_count: got %0d pulses, required 1", vq.size());
        end else if (vq[0].ch != c || vq[0].t !== m_tens[c] || vq[0].o !== m_ones[c]) begin
            miscompares++;
            $display("FAIL valid_event: got ch%0d %0d/%0d, required ch%0d %0d/%0d",
                     vq[0].ch, vq[0].t, vq[0].o, c, m_tens[c], m_ones[c]);
        end
        vectors++;
        if ({tens0_o, ones0_o, tens1_o, ones1_o} !== {m_tens[0], m_ones[0], m_tens[1], m_ones[1]}) begin
            miscompares++;
            $display("FAIL results: got %h, required %h", {tens0_o, ones0_o, tens1_o, ones1_o},
                     {m_tens[0], m_ones[0], m_tens[1], m_ones[1]});
        end
        vectors++;
        if ({ovf_o, err_o, valid_o} !== {m_ovf, m_err, 2'b00} || start_count - s0 != 1) begin
            miscompares++;
            $display("FAIL flags: ovf/err/valid got %b/%b/%b starts %0d, required %b/%b/00 starts 1",
                     ovf_o, err_o, valid_o, start_count - s0, m_ovf, m_err);
        end
    endtask

    // Both channels requested on the same edge.
    task automatic both_xfer(input logic [6:0] b0, input logic [6:0] b1, input int d);
        int         first  = (m_last == 1) ? 0 : 1;
        int         second = 1 - first;
        int         s0     = start_count;
        logic [6:0] bb[2];
        bb[0] = b0;
        bb[1] = b1;
        vq.delete();
        conv_delay = d;
        bin0_i = b0;
        bin1_i = b1;
        req_i  = 2'b11;
        tick();
        req_i = 2'b00;
        wait_events(2, 120);
        settle(20);
        for (int k = 0; k < 2; k++) begin
            m_tens[k] = 4'(clamp_op(bb[k]) / 7'd10);
            m_ones[k] = 4'(clamp_op(bb[k]) % 7'd10);
            m_ovf[k]  = ovf_of(bb[k]);
        end
        m_last = second;
        vectors++;
        if (vq.size() != 2) begin
            miscompares++; $display("FAIL pair_count: got %0d pulses, required 2", vq.size());
        end else begin
            vectors++;
            if (vq[0].ch != first || vq[0].t !== m_tens[first] || vq[0].o !== m_ones[first]) begin
                miscompares++;
                $display("FAIL pair_first: got ch%0d %0d/%0d, required ch%0d %0d/%0d",
                         vq[0].ch, vq[0].t, vq[0].o, first, m_tens[first], m_ones[first]);
            end
            vectors++;
            if (vq[1].ch != second || vq[1].t !== m_tens[second] || vq[1].o !== m_ones[second]) begin
                miscompares++;
                $display("FAIL pair_second: got ch%0d %0d/%0d, required ch%0d %0d/%0d",
                         vq[1].ch, vq[1].t, vq[1].o, second, m_tens[second], m_ones[second]);
            end
        end
        vectors++;
        if ({tens0_o, ones0_o, tens1_o, ones1_o, ovf_o} !==
            {m_tens[0], m_ones[0], m_tens[1], m_ones[1], m_ovf} || start_count - s0 != 2) begin
            miscompares++;
            $display("FAIL pair_state: got %h ovf %b starts %0d, required %h ovf %b starts 2",
                     {tens0_o, ones0_o, tens1_o, ones1_o}, ovf_o, start_count - s0,
                     {m_tens[0], m_ones[0], m_tens[1], m_ones[1]}, m_ovf);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({tens0_o, ones0_o, tens1_o, ones1_o, valid_o, ovf_o} !== 20'h0) begin
            miscompares++; $display("FAIL reset_data: got %h, required 0", {tens0_o, ones0_o, tens1_o, ones1_o, valid_o, ovf_o});
        end
        vectors++;
        if ({cif.conv_start_o, cif.conv_bin_o, busy_o, err_o} !== 10'h0) begin
            miscompares++; $display("FAIL reset_ctrl: got %h, required 0", {cif.conv_start_o, cif.conv_bin_o, busy_o, err_o});
        end
    endtask

    task automatic test_single();
        do_reset();
        single_xfer(0, 7'd42, 8);
        for (int n = 0; n < 8; n++)
            single_xfer(int'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), int'($urandom_range(1, 12)));
    endtask

    task automatic test_both();
        do_reset();
        both_xfer(7'd7, 7'd93, 5);
        for (int n = 0; n < 6; n++)
            both_xfer(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), int'($urandom_range(1, 12)));
    endtask

    task automatic test_clamp();
        single_xfer(1, 7'd120, 6);
        single_xfer(1, 7'd15, 3);
        single_xfer(0, 7'd99, 2);
        single_xfer(0, 7'd100, 2);
        for (int n = 0; n < 4; n++)
            single_xfer(int'($urandom_range(0, 1)), 7'($urandom_range(100, 127)), int'($urandom_range(1, 12)));
    endtask

    task automatic test_timeout();
        int c;
        int n;
        int s0;
        logic [6:0] b;
        do_reset();
        single_xfer(0, 7'd57, 3);
        c  = int'($urandom_range(0, 1));
        b  = 7'($urandom_range(0, 127));
        conv_mute = 1'b1;
        vq.delete();
        s0 = start_count;
        if (c == 0) bin0_i = b; else bin1_i = b;
        req_i = 2'(1 << c);
        tick();
        req_i = 2'b00;
        n = 0;
        while (cif.conv_start_o !== 1'b1 && n < 5) begin
            tick();
            n++;
        end
        vectors++;
        if (cif.conv_start_o !== 1'b1 || err_o !== 1'b0) begin
            miscompares++; $display("FAIL to_start: start/err got %b%b, required 10", cif.conv_start_o, err_o);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (busy_o === 1'b1 && n < int'(TIMEOUT) + 10);
        m_ovf[c] = ovf_of(b);
        m_err    = 1'b1;
        m_last   = c;
        vectors++;
        if (n != int'(TIMEOUT) + 1) begin
            miscompares++; $display("FAIL to_busy_len: busy fell after %0d cycles, required %0d", n, TIMEOUT + 1);
        end
        vectors++;
        if (err_o !== 1'b1) begin
            miscompares++; $display("FAIL to_err: got %b, required 1", err_o);
        end
        repeat (10) tick();
        vectors++;
        if (vq.size() != 0 || start_count - s0 != 1 || err_o !== 1'b1 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_after: pulses %0d starts %0d err %b busy %b, required 0 1 1 0",
                     vq.size(), start_count - s0, err_o, busy_o);
        end
        vectors++;
        if ({tens0_o, ones0_o, tens1_o, ones1_o, ovf_o} !== {m_tens[0], m_ones[0], m_tens[1], m_ones[1], m_ovf}) begin
            miscompares++;
            $display("FAIL to_hold: got %h ovf %b, required %h ovf %b", {tens0_o, ones0_o, tens1_o, ones1_o}, ovf_o,
                     {m_tens[0], m_ones[0], m_tens[1], m_ones[1]}, m_ovf);
        end
        conv_mute = 1'b0;
        single_xfer(1 - c, 7'($urandom_range(0, 127)), 4);
    endtask

    task automatic test_rerequest();
        int         s0 = start_count;
        logic [6:0] b1 = 7'($urandom_range(0, 127));
        logic [6:0] b2 = 7'($urandom_range(0, 127));
        vq.delete();
        conv_delay = 8;
        bin0_i = b1;
        req_i  = 2'b01;
        tick();
        req_i = 2'b00;
        tick();
        vectors++;
        if (cif.conv_start_o !== 1'b1 || cif.conv_bin_o !== clamp_op(b1)) begin
            miscompares++; $display("FAIL rr_first: start %b op %0d, required 1 op %0d", cif.conv_start_o, cif.conv_bin_o, clamp_op(b1));
        end
        tick();
        tick();
        bin0_i = b2;
        req_i  = 2'b01;
        tick();
        req_i = 2'b00;
        wait_events(2, 80);
        settle(20);
        m_tens[0] = 4'(clamp_op(b2) / 7'd10);
        m_ones[0] = 4'(clamp_op(b2) % 7'd10);
        m_ovf[0]  = ovf_of(b2);
        m_last    = 0;
        vectors++;
        if (vq.size() != 2) begin
            miscompares++; $display("FAIL rr_count: got %0d pulses, required 2", vq.size());
        end else begin
            vectors++;
            if (vq[0].ch != 0 || vq[0].t !== 4'(clamp_op(b1) / 7'd10) || vq[0].o !== 4'(clamp_op(b1) % 7'd10)) begin
                miscompares++; $display("FAIL rr_ev0: got ch%0d %0d/%0d, required ch0 from %0d", vq[0].ch, vq[0].t, vq[0].o, clamp_op(b1));
            end
            vectors++;
            if (vq[1].ch != 0 || vq[1].t !== m_tens[0] || vq[1].o !== m_ones[0]) begin
                miscompares++; $display("FAIL rr_ev1: got ch%0d %0d/%0d, required ch0 %0d/%0d", vq[1].ch, vq[1].t, vq[1].o, m_tens[0], m_ones[0]);
            end
        end
        vectors++;
        if (start_count - s0 != 2 || ovf_o !== m_ovf) begin
            miscompares++; $display("FAIL rr_state: starts %0d ovf %b, required 2 ovf %b", start_count - s0, ovf_o, m_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        int c = int'($urandom_range(0, 1));
        conv_delay = 10;
        if (c == 0) bin0_i = 7'($urandom_range(0, 127)); else bin1_i = 7'($urandom_range(0, 127));
        req_i = 2'(1 << c);
        tick();
        req_i = 2'b00;
        tick();
        repeat (3) tick();
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++; $display("FAIL mid_busy: got %b, required 1", busy_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        model_clear();
        vectors++;
        if ({tens0_o, ones0_o, tens1_o, ones1_o, valid_o, ovf_o, cif.conv_start_o, cif.conv_bin_o, busy_o, err_o} !== 30'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got %h, required 0",
                     {tens0_o, ones0_o, tens1_o, ones1_o, valid_o, ovf_o, cif.conv_start_o, cif.conv_bin_o, busy_o, err_o});
        end
        vq.delete();
        s0 = start_count;
        repeat (15) tick();
        vectors++;
        if (vq.size() != 0 || busy_o !== 1'b0 || start_count != s0 || {tens0_o, ones0_o, tens1_o, ones1_o} !== 16'h0) begin
            miscompares++;
            $display("FAIL late_done: pulses %0d busy %b starts %0d results %h, required 0 0 0 0",
                     vq.size(), busy_o, start_count - s0, {tens0_o, ones0_o, tens1_o, ones1_o});
        end
        both_xfer(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 3);
    endtask

    task automatic test_protocol();
        vectors++;
        if (viol != 0) begin
            miscompares++; $display("FAIL protocol: got %0d start/hold violations, required 0", viol);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_both();
        test_clamp();
        test_timeout();
        test_rerequest();
        test_reset_mid();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
